// File: rtl/mem_access_ctrl_pkg.sv
// Shared encodings and helpers for the MEM-stage access controller.
package mem_access_ctrl_pkg;

  localparam int unsigned DATA_LEN = 64;
  localparam int unsigned STRB_LEN = 8;

  localparam logic [1:0] MEM_B = 2'b00;
  localparam logic [1:0] MEM_H = 2'b01;
  localparam logic [1:0] MEM_W = 2'b10;
  localparam logic [1:0] MEM_D = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_RESP = 2'b10,
    ST_DONE = 2'b11
  } state_e;

  function automatic logic [STRB_LEN-1:0] size_mask(input logic [1:0] size);
    case (size)
      MEM_B:   size_mask = 8'h01;
      MEM_H:   size_mask = 8'h03;
      MEM_W:   size_mask = 8'h0F;
      default: size_mask = 8'hFF;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] off);
    case (size)
      MEM_B:   is_misaligned = 1'b0;
      MEM_H:   is_misaligned = off[0];
      MEM_W:   is_misaligned = |off[1:0];
      default: is_misaligned = |off;
    endcase
  endfunction

  function automatic logic [DATA_LEN-1:0] replicate(input logic [1:0] size,
                                                    input logic [DATA_LEN-1:0] data);
    case (size)
      MEM_B:   replicate = {8{data[7:0]}};
      MEM_H:   replicate = {4{data[15:0]}};
      MEM_W:   replicate = {2{data[31:0]}};
      default: replicate = data;
    endcase
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load-data alignment: shift by byte offset, select access size, sign/zero extend.
module mem_load_align
  import mem_access_ctrl_pkg::*;
(
  input  logic [2:0]          funct3_i,
  input  logic [2:0]          offset_i,
  input  logic [DATA_LEN-1:0] rdata_i,
  output logic [DATA_LEN-1:0] data_o
);

  logic [DATA_LEN-1:0] shifted;
  logic                uns;

  assign shifted = rdata_i >> {offset_i, 3'b000};
  assign uns     = funct3_i[2];

  always_comb begin
    data_o = shifted;
    case (funct3_i[1:0])
      MEM_B:   data_o = {{56{~uns & shifted[7]}},  shifted[7:0]};
      MEM_H:   data_o = {{48{~uns & shifted[15]}}, shifted[15:0]};
      MEM_W:   data_o = {{32{~uns & shifted[31]}}, shifted[31:0]};
      default: data_o = shifted;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store sequencer with bus handshake and pipeline hold.
// Optional bus-wait timeout enabled by MEM_ACCESS_CTRL_TIMEOUT_EN.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [2:0]          funct3_i,
  input  logic                visit_sig_i,
  input  logic                wmem_en_i,
  input  logic [DATA_LEN-1:0] addr_i,
  input  logic [DATA_LEN-1:0] wdata_i,
  output logic                hold_o,
  output logic                req_o,
  output logic                we_o,
  output logic [DATA_LEN-1:0] addr_o,
  output logic [DATA_LEN-1:0] wdata_o,
  output logic [STRB_LEN-1:0] wstrb_o,
  input  logic                gnt_i,
  input  logic                rvalid_i,
  input  logic [DATA_LEN-1:0] rdata_i,
  output logic                ld_valid_o,
  output logic [DATA_LEN-1:0] ld_data_o,
  output logic                misalign_o,
  output logic                bus_err_o
);

  if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be nonzero");
  end

  state_e              state_q, state_d;
  logic [DATA_LEN-1:0] ld_data_q, ld_data_d;
  logic                ld_valid_q, ld_valid_d;
  logic                bus_err_q, bus_err_d;
  logic [DATA_LEN-1:0] ld_aligned;
  logic                active, misaligned, timeout;

  assign active     = visit_sig_i | wmem_en_i;
  assign misaligned = is_misaligned(funct3_i[1:0], addr_i[2:0]);

  mem_load_align u_align (
    .funct3_i (funct3_i),
    .offset_i (addr_i[2:0]),
    .rdata_i  (rdata_i),
    .data_o   (ld_aligned)
  );

`ifdef MEM_ACCESS_CTRL_TIMEOUT_EN
  logic [31:0] cnt_q, cnt_d;
  logic        busy;

  assign busy = (state_q == ST_REQ) || (state_q == ST_RESP);

  // Every REQ is entered from IDLE, so clearing in IDLE is clearing on entry.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == ST_IDLE) cnt_d = '0;
    else if (busy)          cnt_d = cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign timeout = busy && (cnt_q == 32'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    ld_data_d  = ld_data_q;
    ld_valid_d = 1'b0;
    bus_err_d  = 1'b0;
    hold_o     = 1'b0;
    req_o      = 1'b0;
    we_o       = 1'b0;
    addr_o     = '0;
    wdata_o    = '0;
    wstrb_o    = '0;
    misalign_o = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (active) begin
          if (misaligned) begin
            misalign_o = 1'b1;
          end else begin
            hold_o  = 1'b1;
            state_d = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        hold_o  = 1'b1;
        req_o   = 1'b1;
        we_o    = wmem_en_i;
        addr_o  = {addr_i[DATA_LEN-1:3], 3'b000};
        wdata_o = replicate(funct3_i[1:0], wdata_i);
        wstrb_o = size_mask(funct3_i[1:0]) << addr_i[2:0];
        // Abort takes priority over a grant arriving in the same cycle.
        if (timeout) begin
          bus_err_d = 1'b1;
          ld_data_d = '0;
          state_d   = ST_DONE;
        end else if (gnt_i) begin
          state_d = wmem_en_i ? ST_DONE : ST_RESP;
        end
      end
      ST_RESP: begin
        hold_o = 1'b1;
        if (timeout) begin
          bus_err_d = 1'b1;
          ld_data_d = '0;
          state_d   = ST_DONE;
        end else if (rvalid_i) begin
          ld_data_d  = ld_aligned;
          ld_valid_d = 1'b1;
          state_d    = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      ld_data_q  <= '0;
      ld_valid_q <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ld_data_q  <= ld_data_d;
      ld_valid_q <= ld_valid_d;
      bus_err_q  <= bus_err_d;
    end
  end

  assign ld_data_o  = ld_data_q;
  assign ld_valid_o = ld_valid_q;
  assign bus_err_o  = bus_err_q;

endmodule
